// File: rtl/vco_adc_pkg.sv
// Shared types and widths for the VCO-ADC sample readout path.
package vco_adc_pkg;

  localparam int unsigned VCO_ADC_DATA_W  = 32;
  localparam int unsigned VCO_ADC_FRAME_W = 16;

  typedef logic [VCO_ADC_DATA_W-1:0] vco_adc_sample_t;

endpackage

// File: rtl/vco_adc_out_buf.sv
// Circular output buffer for the FIFO reader: push, pop, occupancy and head entry.
module vco_adc_out_buf
  import vco_adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VCO_ADC_DATA_W,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       push_data,
  input  logic                        pop,
  output logic [$clog2(DEPTH):0]      occ,
  output logic [DATA_WIDTH-1:0]       head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q;
  logic [AW:0]           rd_ptr_q;

  // Pointers carry one extra bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign occ  = wr_ptr_q - rd_ptr_q;
  assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vco_adc_fifo_reader.sv
// Drain side of the VCO-ADC sample FIFO: credit-based reads into a small buffer, valid/ready out.
// Define VCO_ADC_READER_LAST_EN to build the frame counter that drives m_last_o.
module vco_adc_fifo_reader
  import vco_adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = VCO_ADC_DATA_W,
  parameter int unsigned OUT_DEPTH  = 4,
  parameter int unsigned FRAME_W    = VCO_ADC_FRAME_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  input  logic [FRAME_W-1:0]    frame_len_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_read_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic                  busy_o
);

  localparam int unsigned AW = $clog2(OUT_DEPTH);
  localparam logic [AW+1:0] DepthLim = (AW+2)'(OUT_DEPTH);

  logic                  inflight_q;
  logic [AW:0]           occ;
  logic [DATA_WIDTH-1:0] head;
  logic [AW+1:0]         credit_used;
  logic                  accept;

  vco_adc_out_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OUT_DEPTH)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (fifo_data_i),
    .pop       (accept),
    .occ       (occ),
    .head      (head)
  );

  // Credit counts only registered state, so m_ready_i never reaches fifo_read_o.
  assign credit_used = {1'b0, occ} + {{(AW+1){1'b0}}, inflight_q};
  assign fifo_read_o = ~rst & enable_i & ~fifo_empty_i & (credit_used < DepthLim);

  always_ff @(posedge clk) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= fifo_read_o;
  end

  assign m_valid_o = (occ != '0);
  assign accept    = m_valid_o & m_ready_i;
  assign m_data_o  = m_valid_o ? head : '0;
  assign busy_o    = inflight_q | m_valid_o;

`ifdef VCO_ADC_READER_LAST_EN
  logic [FRAME_W-1:0] frame_cnt_q;
  logic               last;

  assign last = (frame_len_i != '0) & m_valid_o & (frame_cnt_q == frame_len_i - FRAME_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (accept) begin
      frame_cnt_q <= last ? '0 : frame_cnt_q + FRAME_W'(1);
    end
  end

  assign m_last_o = last;
`else
  logic unused_frame_len;
  assign unused_frame_len = ^frame_len_i;
  assign m_last_o         = 1'b0;
`endif

endmodule

// File: tb/tb_vco_adc_fifo_reader.sv
// Randomized bench for vco_adc_fifo_reader against a queue-based FIFO and stream model.
module tb_vco_adc_fifo_reader;
  import vco_adc_pkg::*;

  localparam int unsigned Depth = 4;
  localparam int unsigned FW    = VCO_ADC_FRAME_W;
`ifdef VCO_ADC_READER_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            enable_i;
  logic [FW-1:0]   frame_len_i;
  logic            fifo_empty_i;
  vco_adc_sample_t fifo_data_i;
  logic            fifo_read_o;
  logic            m_valid_o;
  logic            m_ready_i;
  vco_adc_sample_t m_data_o;
  logic            m_last_o;
  logic            busy_o;

  always #5 clk = ~clk;

  vco_adc_fifo_reader #(
    .DATA_WIDTH (VCO_ADC_DATA_W),
    .OUT_DEPTH  (Depth),
    .FRAME_W    (FW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .frame_len_i  (frame_len_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_read_o  (fifo_read_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .busy_o       (busy_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // src_q: FIFO contents; exp_q: samples not yet delivered; rd_cyc_q: issue cycle per outstanding read
  vco_adc_sample_t src_q[$];
  vco_adc_sample_t exp_q[$];
  int              rd_cyc_q[$];
  int              cyc = 0;
  int              beat_cnt = 0;
  bit              rst_req = 1'b1;
  bit              rd_prev = 1'b0;
  int              n_reads, n_beats, n_last, first_rd, first_valid, last_beat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_reads = 0; n_beats = 0; n_last = 0;
    first_rd = -1; first_valid = -1; last_beat = -1;
  endtask

  task automatic push(input vco_adc_sample_t v);
    src_q.push_back(v);
    exp_q.push_back(v);
  endtask

  // One clock: update the FIFO model after the edge, drive inputs, then check outputs.
  task automatic step(input bit en, input bit rdy);
    bit              exp_valid, exp_rd, exp_last;
    vco_adc_sample_t exp_data;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      src_q.delete(); exp_q.delete(); rd_cyc_q.delete();
      beat_cnt = 0;
      fifo_data_i = '0;
    end else if (rd_prev) begin
      fifo_data_i = src_q.pop_front();
    end
    rst          = rst_req;
    enable_i     = en;
    m_ready_i    = rdy;
    fifo_empty_i = (src_q.size() == 0);
    #1;
    exp_valid = (rd_cyc_q.size() != 0) && (rd_cyc_q[0] + 2 <= cyc);
    exp_data  = (exp_valid && exp_q.size() != 0) ? exp_q[0] : '0;
    exp_rd    = !rst_req && en && (src_q.size() != 0) && (rd_cyc_q.size() < Depth);
    exp_last  = LastEn && exp_valid && (frame_len_i != 0) &&
                (beat_cnt % frame_len_i == frame_len_i - 1);
    check("fifo_read", fifo_read_o, exp_rd);
    check("m_valid", m_valid_o, exp_valid);
    check("m_data", m_data_o, exp_data);
    check("m_last", m_last_o, exp_last);
    check("busy", busy_o, rd_cyc_q.size() != 0);
    if (m_valid_o && first_valid < 0) first_valid = cyc;
    if (fifo_read_o) begin
      rd_cyc_q.push_back(cyc);
      n_reads++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (m_valid_o && m_ready_i) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      else check("spurious_beat", 1'b1, 1'b0);
      if (rd_cyc_q.size() != 0) void'(rd_cyc_q.pop_front());
      if (m_last_o) n_last++;
      beat_cnt++;
      n_beats++;
      last_beat = cyc;
    end
    rd_prev = fifo_read_o;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step(1'b0, 1'b0);
    rst_req = 1'b0;
    step(1'b0, 1'b0);
  endtask

  initial begin
    int empty_low, pushed, rd_before;
    rst = 1'b1; enable_i = 1'b0; m_ready_i = 1'b0; fifo_empty_i = 1'b1;
    fifo_data_i = '0; frame_len_i = '0;

    do_reset();
    check("reset_valid", m_valid_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    check("reset_data", m_data_o, 0);

    // Basic drain
    clear_stats();
    for (int i = 0; i < 8; i++) push(32'h100 + i);
    step(1'b1, 1'b1);
    empty_low = cyc;
    for (int k = 0; k < 40 && n_beats < 8; k++) step(1'b1, 1'b1);
    check("drain_first_read", first_rd, empty_low);
    check("drain_latency", first_valid, first_rd + 2);
    check("drain_consecutive", last_beat, first_valid + 7);
    check("drain_count", n_beats, 8);
    step(1'b1, 1'b1);
    check("drain_busy_fall", busy_o, 1'b0);

    // Backpressure
    clear_stats();
    for (int i = 0; i < 16; i++) push(32'h300 + i);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
    check("bp_reads", n_reads, 4);
    check("bp_no_beats", n_beats, 0);
    for (int k = 0; k < 80 && n_beats < 16; k++) step(1'b1, 1'b1);
    check("bp_count", n_beats, 16);
    check("bp_left", exp_q.size(), 0);

    // Random ready, bursty source
    clear_stats();
    pushed = 0;
    for (int k = 0; k < 20000 && n_beats < 1000; k++) begin
      if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
        for (int j = $urandom_range(1, 3); j > 0 && pushed < 1000; j--) begin
          push($urandom);
          pushed++;
        end
      end
      step(1'b1, 1'($urandom_range(0, 1)));
    end
    check("rand_count", n_beats, 1000);
    check("rand_left", exp_q.size(), 0);

    // Frame marking from a clean counter
    for (int k = 0; k < 20 && busy_o; k++) step(1'b1, 1'b1);
    do_reset();
    frame_len_i = 16'd5;
    clear_stats();
    for (int i = 0; i < 12; i++) push(32'h400 + i);
    for (int k = 0; k < 400 && n_beats < 12; k++) step(1'b1, 1'($urandom_range(0, 1)));
    check("frame_count", n_beats, 12);
    check("frame_lasts", n_last, LastEn ? 2 : 0);
    for (int k = 0; k < 20 && busy_o; k++) step(1'b1, 1'b1);
    frame_len_i = '0;
    do_reset();

    // Enable toggling
    clear_stats();
    for (int i = 0; i < 6; i++) push(32'h500 + i);
    for (int k = 0; k < 10 && n_reads == 0; k++) step(1'b1, 1'b1);
    rd_before = n_reads;
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1);
    check("en_no_reads", n_reads, rd_before);
    check("en_inflight_delivered", n_beats, rd_before);
    for (int k = 0; k < 40 && n_beats < 6; k++) step(1'b1, 1'b1);
    check("en_resume_count", n_beats, 6);

    // Reset with three samples buffered
    clear_stats();
    for (int i = 0; i < 8; i++) push(32'h600 + i);
    for (int k = 0; k < 10 && n_reads < 3; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    check("rst_buffered_valid", m_valid_o, 1'b1);
    rst_req = 1'b1;
    step(1'b0, 1'b0);
    rst_req = 1'b0;
    step(1'b1, 1'b1);
    check("rst_mid_valid", m_valid_o, 1'b0);
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_data", m_data_o, 0);
    check("rst_mid_read", fifo_read_o, 1'b0);
    clear_stats();
    for (int i = 0; i < 4; i++) push(32'h700 + i);
    for (int k = 0; k < 40 && n_beats < 4; k++) step(1'b1, 1'b1);
    check("rst_fresh_count", n_beats, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
